// File: rtl/idq_pkg.sv
// Shared constants for the fetch->decode instruction queue: RV32I opcodes,
// immediate-type select encodings and the canonical NOP.
package idq_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_sel_dec.sv
// Combinational opcode -> {imm_sel, illegal} decoder; reusable by later decode logic.
module imm_sel_dec
    import idq_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic       illegal
);

    always_comb begin
        imm_sel = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_sel = IMM_I;
            OPC_STORE:                      imm_sel = IMM_S;
            OPC_BRANCH:                     imm_sel = IMM_B;
            OPC_JAL:                        imm_sel = IMM_J;
            OPC_LUI, OPC_AUIPC:             imm_sel = IMM_U;
            // R-type, system and fence carry no immediate but are legal
            OPC_OP, OPC_SYSTEM, OPC_FENCE:  imm_sel = IMM_I;
            default:                        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_fetch_queue.sv
// Circular instruction queue between fetch and decode with pre-decoded imm_sel.
// Define IDQ_BYPASS_EN for zero-latency pass-through when the queue is empty.
module id_fetch_queue
    import idq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      imm_sel,
    output logic [24:0]     imm_field,
    output logic            illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic head_valid, byp, push, pop, wr_en, rd_en;

    assign head_valid = (count != '0);
    assign in_ready   = !rst && (count != CW'(DEPTH));

`ifdef IDQ_BYPASS_EN
    // Empty queue: show the incoming entry directly; it is only stored if decode stalls.
    assign byp = !head_valid && in_valid && !rst;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = !flush && (head_valid || byp);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && !flush && !(byp && out_ready);
    assign rd_en     = pop && !byp;

    always_comb begin
        out_instr = XLEN'(NOP_INSTR);
        out_pc    = '0;
        if (out_valid) begin
            if (byp) begin
                out_instr = in_instr;
                out_pc    = in_pc;
            end else begin
                out_instr = mem_instr[rd_ptr];
                out_pc    = mem_pc[rd_ptr];
            end
        end
    end

    assign imm_field = out_instr[31:7];

    imm_sel_dec u_dec (
        .opcode  (out_instr[6:0]),
        .imm_sel (imm_sel),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !rd_en)      count <= count + CW'(1);
            else if (!wr_en && rd_en) count <= count - CW'(1);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

endmodule

// File: tb/tb_id_fetch_queue.sv
// Directed bench for id_fetch_queue: reset, fill/drain, streaming, flush, decode, bypass.
module tb_id_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [2:0]  imm_sel;
    logic [24:0] imm_field;

    int vectors    = 0;
    int miscompares = 0;

`ifdef IDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    id_fetch_queue #(.DEPTH(2), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .imm_sel   (imm_sel),
        .imm_field (imm_field),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set after this settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_head;
    logic [31:0] dec_instr [6];
    logic [2:0]  dec_sel   [6];
    logic        dec_ill   [6];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_instr = 32'hDEAD_BEEF; in_pc = 32'h0;

        // Reset held two cycles with fetch offering
        tick(); settle();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        tick(); settle();
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick(); settle();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Fill two entries, decode stalled
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h0;
        tick();
        in_instr = 32'h0011_2223; in_pc = 32'h4;
        tick();
        in_valid = 1'b0; settle();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("head_valid", {31'd0, out_valid}, 32'd1);
        chk("head_instr", out_instr, 32'h0050_0093);
        chk("head_pc", out_pc, 32'h0);
        chk("head_imm_sel", {29'd0, imm_sel}, 32'd0);
        chk("head_imm_field", {7'd0, imm_field}, 32'h0000_A001);
        chk("head_illegal", {31'd0, illegal}, 32'd0);

        // Single pop
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; settle();
        chk("pop_instr", out_instr, 32'h0011_2223);
        chk("pop_imm_sel", {29'd0, imm_sel}, 32'd1);
        chk("pop_pc", out_pc, 32'h4);
        chk("pop_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming push+pop with one entry resident
        exp_head = 32'h0011_2223;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_instr = 32'h0000_0013 | ((i + 1) << 20);
            in_pc    = 32'h100 + 4 * i;
            settle();
            chk("stream_head", out_instr, exp_head);
            chk("stream_ready", {30'd0, in_ready, out_valid}, 32'd3);
            exp_head = in_instr;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0; settle();
        chk("stream_last_instr", out_instr, 32'h00A0_0013);
        chk("stream_last_pc", out_pc, 32'h124);
        chk("stream_count1", {30'd0, in_ready, out_valid}, 32'd3);

        // Fill, then flush with an entry on offer
        in_valid = 1'b1; in_instr = 32'h0030_0093; in_pc = 32'h128;
        tick();
        in_instr = 32'h0070_0093; in_pc = 32'h12C; flush = 1'b1; settle();
        chk("flush_cycle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cycle_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; settle();
        chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_flush_out_instr", out_instr, 32'h0000_0013);
        chk("post_flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); settle();
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        // Decode sweep
        dec_instr[0] = 32'h0000_006F; dec_sel[0] = 3'b011; dec_ill[0] = 1'b0;
        dec_instr[1] = 32'h0000_0037; dec_sel[1] = 3'b100; dec_ill[1] = 1'b0;
        dec_instr[2] = 32'hFE00_0EE3; dec_sel[2] = 3'b010; dec_ill[2] = 1'b0;
        dec_instr[3] = 32'h0000_007F; dec_sel[3] = 3'b000; dec_ill[3] = 1'b1;
        dec_instr[4] = 32'h0000_0033; dec_sel[4] = 3'b000; dec_ill[4] = 1'b0;
        dec_instr[5] = 32'h0000_0017; dec_sel[5] = 3'b100; dec_ill[5] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_instr = dec_instr[k]; in_pc = 32'h200 + 4 * k;
            tick();
            in_valid = 1'b0; settle();
            chk("dec_valid", {31'd0, out_valid}, 32'd1);
            chk("dec_imm_sel", {29'd0, imm_sel}, {29'd0, dec_sel[k]});
            chk("dec_illegal", {31'd0, illegal}, {31'd0, dec_ill[k]});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        settle();
        chk("dec_drained", {31'd0, out_valid}, 32'd0);

        // Empty queue, entry offered with decode ready
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h300;
        settle();
        chk("byp_same_cycle_valid", {31'd0, out_valid}, {31'd0, BYP});
        chk("byp_same_cycle_pc", out_pc, BYP ? 32'h300 : 32'h0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0; settle();
        chk("byp_next_cycle_valid", {31'd0, out_valid}, {31'd0, !BYP});
        chk("byp_next_cycle_pc", out_pc, BYP ? 32'h0 : 32'h300);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; settle();
        chk("byp_drained", {31'd0, out_valid}, 32'd0);

        // Mid-operation reset
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h400;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick(); settle();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        tick(); settle();
        chk("mid_rst_release", {30'd0, in_ready, out_valid}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
